nibble_serial_adder: RTL and testbench

- Multi-cycle W-bit adder/subtractor for the CPU datapath, built by sequencing operands through one sum_nibble instance, one nibble per clock, least-significant nibble first.
- Sits directly upstream of sum_nibble: slices operands into nibbles, drives its a/b/c0 inputs, and consumes its s/c4 outputs into a result register and carry register.
- Trades latency for area. The ALU issues a start pulse and waits for done.

---
 rtl/nibble_serial_adder.sv | 121 ++++++++++++
 tb/tb_nibble_serial_adder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// Multi-cycle W-bit add/subtract, one nibble per clock through a single sum_nibble.
// Optional zero/ovf status outputs are enabled with `define STATUS_FLAGS_EN.

module sum_nibble (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c0,
  output logic [3:0] s,
  output logic       c4
);
  assign {c4, s} = {1'b0, a} + {1'b0, b} + {4'b0000, c0};
endmodule

// state | meaning
// IDLE  | waiting for start; sum/cout hold the last result
// RUN   | one nibble per clock, LS nibble first
// DONE  | result valid, done pulses for this single cycle
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 sub,
  input  logic [4*NIBBLES-1:0] op_a,
  input  logic [4*NIBBLES-1:0] op_b,
  input  logic                 cin,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout
`ifdef STATUS_FLAGS_EN
  ,
  output logic                 zero,
  output logic                 ovf
`endif
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] idx;
  logic [W-1:0]  a_reg, b_reg;
  logic          carry;
  logic [3:0]    nib_s;
  logic          nib_c4;
  logic [W-1:0]  sum_nxt;

  sum_nibble u_nib (
    .a  (a_reg[4*idx +: 4]),
    .b  (b_reg[4*idx +: 4]),
    .c0 (carry),
    .s  (nib_s),
    .c4 (nib_c4)
  );

  // Full result as it will look after this edge; the flags need the top nibble included.
  always_comb begin
    sum_nxt = sum;
    sum_nxt[4*idx +: 4] = nib_s;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (idx == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx   <= '0;
      a_reg <= '0;
      b_reg <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef STATUS_FLAGS_EN
      zero  <= 1'b0;
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          a_reg <= op_a;
          b_reg <= sub ? ~op_b : op_b;
          carry <= cin ^ sub;
          idx   <= '0;
        end
        RUN: begin
          sum[4*idx +: 4] <= nib_s;
          carry <= nib_c4;
          if (idx == LAST) begin
            cout <= nib_c4;
`ifdef STATUS_FLAGS_EN
            zero <= (sum_nxt == '0);
            ovf  <= (a_reg[W-1] == b_reg[W-1]) && (sum_nxt[W-1] != a_reg[W-1]);
`endif
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder (NIBBLES=4) with an expected-result queue.
// Flag outputs are checked only when STATUS_FLAGS_EN is defined.

module tb_nibble_serial_adder;
  logic        clk = 1'b0;
  logic        rst_n, start, sub, cin;
  logic [15:0] op_a, op_b;
  logic        busy, done, cout;
  logic [15:0] sum;
`ifdef STATUS_FLAGS_EN
  logic        zero, ovf;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        z;
    logic        v;
  } exp_t;

  exp_t sb[$];

  nibble_serial_adder #(.NIBBLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .op_a  (op_a),
    .op_b  (op_b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef STATUS_FLAGS_EN
    ,
    .zero  (zero),
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Integer reference: add = a+b+cin, sub = a-b-borrow; signed range decides ovf.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic s, input logic ci);
    exp_t e;
    int   ua, ub, ur, sa, sbv, sr;
    ua  = int'(a);
    ub  = int'(b);
    sa  = int'($signed(a));
    sbv = int'($signed(b));
    if (!s) begin
      ur  = ua + ub + int'(ci);
      sr  = sa + sbv + int'(ci);
      e.c = (ur > 65535);
    end else begin
      ur  = ua - ub - int'(ci);
      sr  = sa - sbv - int'(ci);
      e.c = (ur >= 0);
    end
    e.s = 16'(ur);
    e.z = (e.s == 16'h0000);
    e.v = (sr > 32767) || (sr < -32768);
    return e;
  endfunction

  task automatic compare_result(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_sum"}, 32'(sum), 32'(e.s));
    chk({tag, "_cout"}, 32'(cout), 32'(e.c));
`ifdef STATUS_FLAGS_EN
    chk({tag, "_zero"}, 32'(zero), 32'(e.z));
    chk({tag, "_ovf"}, 32'(ovf), 32'(e.v));
`endif
  endtask

  // Called away from a clock edge; returns #1 after the edge that ends the DONE cycle.
  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic s, input logic ci);
    int n;
    op_a = a; op_b = b; sub = s; cin = ci; start = 1'b1;
    sb.push_back(model(a, b, s, ci));
    @(posedge clk); #1;
    start = 1'b0;
    op_a = 16'($urandom); op_b = 16'($urandom); sub = 1'($urandom); cin = 1'($urandom);
    chk({tag, "_busy_e0"}, 32'(busy), 32'd1);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done) begin n = i; break; end
      chk({tag, "_busy_run"}, 32'(busy), 32'd1);
    end
    chk({tag, "_latency"}, 32'(n), 32'd4);
    chk({tag, "_busy_done"}, 32'(busy), 32'd1);
    compare_result(tag);
    @(posedge clk); #1;
    chk({tag, "_done_drop"}, 32'(done), 32'd0);
    chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
  endtask

  logic [15:0] held;

  initial begin
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; op_a = '0; op_b = '0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
`ifdef STATUS_FLAGS_EN
    chk("rst_zero", 32'(zero), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
`endif
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("add", 16'h1234, 16'h0FFF, 1'b0, 1'b0);
    chk("add_abs_sum", 32'(sum), 32'h2233);
    repeat (3) @(posedge clk);
    #1 chk("add_hold", 32'(sum), 32'h2233);

    do_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    do_op("sub", 16'h0005, 16'h0007, 1'b1, 1'b0);
    chk("sub_abs_sum", 32'(sum), 32'hFFFE);
    do_op("sub_bin", 16'h0005, 16'h0007, 1'b1, 1'b1);
    chk("sub_bin_abs_sum", 32'(sum), 32'hFFFD);
    do_op("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    do_op("ovf_sub", 16'h8000, 16'h0001, 1'b1, 1'b0);
    do_op("sub_nb", 16'h0009, 16'h0003, 1'b1, 1'b0);
    do_op("add_cin", 16'hA5A5, 16'h5A5A, 1'b0, 1'b1);

    // start while busy: pulses in RUN and in DONE must be ignored
    op_a = 16'h1111; op_b = 16'h2222; sub = 1'b0; cin = 1'b0; start = 1'b1;
    sb.push_back(model(16'h1111, 16'h2222, 1'b0, 1'b0));
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    op_a = 16'hAAAA; op_b = 16'h0F0F; sub = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("busy_start_done", 32'(done), 32'd1);
    compare_result("busy_start");
    op_a = 16'h4444; op_b = 16'h4444; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_start_idle", 32'(busy), 32'd0);
    chk("busy_start_hold", 32'(sum), 32'h3333);
    do_op("b2b", 16'h0102, 16'h0304, 1'b0, 1'b0);
    do_op("b2b2", 16'h0F00, 16'h0100, 1'b0, 1'b0);

    // asynchronous reset after E2
    op_a = 16'h1111; op_b = 16'h1111; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    held = sum;
    chk("mid_sum_partial", 32'(held[7:0]), 32'h22);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_sum", 32'(sum), 32'd0);
    chk("mid_rst_cout", 32'(cout), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_idle", 32'(busy), 32'd0);
    do_op("post_rst", 16'h0001, 16'h0001, 1'b0, 1'b0);
    chk("post_rst_abs_sum", 32'(sum), 32'h0002);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
